// File: rtl/axi4_lite_slave_pkg.sv
// Shared definitions for the AXI4-Lite register slave.
// Holds the response codes, default bus widths and the write/read FSM state encodings.
// No ports; imported by the interface users and the slave top.
package axi4_lite_Defs;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_WAIT_W,
    WR_WAIT_AW,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

endpackage

// File: rtl/axi4_lite_slave_if.sv
// AXI4-Lite bus bundle between a master (BFM) and the register slave.
// Ports: AW/W/B write channels, AR/R read channels; valid/ready handshakes.
// Modports: master drives requests and response readies, slave drives the rest.
interface axi4_lite_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

endinterface

// File: rtl/axi4_lite_slave_regmem.sv
// DEPTH x 32 word storage with one byte-enabled write port and one registered read port.
// Ports: ACLK/ARESET (sync clear of all words and read data), we/wr_idx/wr_data/wr_strb,
// rd_en/rd_zero/rd_idx -> rd_data (loaded on rd_en, held otherwise; rd_zero forces 0).
module axi4_lite_regmem #(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_strb,
  input  logic             rd_en,
  input  logic             rd_zero,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [DEPTH];

  // Read samples mem before this edge's write lands, so a same-edge
  // read/write collision returns the old word.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
      if (rd_en) rd_data <= rd_zero ? 32'h0 : mem[rd_idx];
    end
  end

endmodule

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite slave backing a small word-addressed register memory.
// Ports: ACLK, ARESET (sync, active-high), bus (slave modport: AW/W/B/AR/R channels).
// Independent write and read FSMs; all readies and response outputs are registered.
module axi4_lite_slave #(
  parameter int ADDR_WIDTH = axi4_lite_Defs::ADDR_WIDTH,
  parameter int DATA_WIDTH = axi4_lite_Defs::DATA_WIDTH,
  parameter int DEPTH      = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  axi4_lite_slave_if.slave  bus
);
  import axi4_lite_Defs::*;

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(4 * DEPTH);

  // Write channel state
  wr_state_t               wr_state;
  logic                    awready;
  logic                    wready;
  logic                    bvalid;
  resp_t                   bresp;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [DATA_WIDTH/8-1:0] w_strb_q;

  logic                    aw_hs;
  logic                    w_hs;
  logic                    commit;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_strb;
  logic                    wr_ok;

  // Read channel state
  rd_state_t               rd_state;
  logic                    arready;
  logic                    rvalid;
  resp_t                   rresp;
  logic                    ar_hs;
  logic                    ar_ok;
  logic [31:0]             rd_data;

  // The commit happens on the edge of whichever handshake arrives last; the
  // payload of the earlier one comes from its capture register, the later
  // one straight off the bus.
  always_comb begin
    aw_hs  = bus.AWVALID && awready;
    w_hs   = bus.WVALID && wready;
    commit = 1'b0;
    case (wr_state)
      WR_IDLE:    commit = aw_hs && w_hs;
      WR_WAIT_W:  commit = w_hs;
      WR_WAIT_AW: commit = aw_hs;
      default:    commit = 1'b0;
    endcase
    wr_addr = (wr_state == WR_WAIT_W)  ? aw_addr_q : bus.AWADDR;
    wr_data = (wr_state == WR_WAIT_AW) ? w_data_q  : bus.WDATA;
    wr_strb = (wr_state == WR_WAIT_AW) ? w_strb_q  : bus.WSTRB;
    wr_ok   = wr_addr < ADDR_LIMIT;
    ar_hs   = bus.ARVALID && arready;
    ar_ok   = bus.ARADDR < ADDR_LIMIT;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state  <= WR_IDLE;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= OKAY;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (commit) begin
      wr_state <= WR_RESP;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b1;
      bresp    <= wr_ok ? OKAY : SLVERR;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (aw_hs) begin
            wr_state  <= WR_WAIT_W;
            aw_addr_q <= bus.AWADDR;
            awready   <= 1'b0;
            wready    <= 1'b1;
          end else if (w_hs) begin
            wr_state <= WR_WAIT_AW;
            w_data_q <= bus.WDATA;
            w_strb_q <= bus.WSTRB;
            awready  <= 1'b1;
            wready   <= 1'b0;
          end else begin
            awready <= 1'b1;
            wready  <= 1'b1;
          end
        end
        WR_RESP: begin
          if (bus.BREADY) begin
            wr_state <= WR_IDLE;
            bvalid   <= 1'b0;
            awready  <= 1'b1;
            wready   <= 1'b1;
          end
        end
        default: ;  // waiting states hold until commit
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_state <= RD_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rresp    <= OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            rd_state <= RD_DATA;
            arready  <= 1'b0;
            rvalid   <= 1'b1;
            rresp    <= ar_ok ? OKAY : SLVERR;
          end else begin
            arready <= 1'b1;
          end
        end
        default: begin
          if (bus.RREADY) begin
            rd_state <= RD_IDLE;
            rvalid   <= 1'b0;
            arready  <= 1'b1;
          end
        end
      endcase
    end
  end

  axi4_lite_regmem #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .we      (commit && wr_ok),
    .wr_idx  (wr_addr[IDX_W+1:2]),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .rd_en   (ar_hs),
    .rd_zero (!ar_ok),
    .rd_idx  (bus.ARADDR[IDX_W+1:2]),
    .rd_data (rd_data)
  );

  assign bus.AWREADY = awready;
  assign bus.WREADY  = wready;
  assign bus.BVALID  = bvalid;
  assign bus.BRESP   = bresp;
  assign bus.ARREADY = arready;
  assign bus.RVALID  = rvalid;
  assign bus.RRESP   = rresp;
  assign bus.RDATA   = rd_data;

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Self-checking bench for axi4_lite_slave (DEPTH=16).
// Inputs change and outputs are sampled on the falling edge; expected B/R
// responses go into scoreboard queues when a request is driven.
module tb_axi4_lite_slave;
  import axi4_lite_Defs::*;

  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  axi4_lite_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  rexp_t       rq[$];
  logic [1:0]  bq[$];
  logic [31:0] model [16];
  int total = 0;
  int bad   = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic clear_model;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
  endtask

  task automatic push_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a < 32'd64) begin
      model[a[5:2]] = merge(model[a[5:2]], d, s);
      bq.push_back(2'b00);
    end else begin
      bq.push_back(2'b10);
    end
  endtask

  task automatic push_read(input logic [31:0] a);
    rexp_t e;
    if (a < 32'd64) begin
      e.data = model[a[5:2]];
      e.resp = 2'b00;
    end else begin
      e.data = 32'h0;
      e.resp = 2'b10;
    end
    rq.push_back(e);
  endtask

  // ---- bus drivers (start and end on a falling edge) ----
  task automatic write_both(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output bit ok);
    logic aw_h, w_h;
    bus.AWADDR = a; bus.AWVALID = 1'b1;
    bus.WDATA = d; bus.WSTRB = s; bus.WVALID = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      aw_h = bus.AWVALID && bus.AWREADY;
      w_h  = bus.WVALID && bus.WREADY;
      @(negedge ACLK);
      if (aw_h) bus.AWVALID = 1'b0;
      if (w_h)  bus.WVALID  = 1'b0;
      if (!bus.AWVALID && !bus.WVALID) begin ok = 1'b1; break; end
    end
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
  endtask

  task automatic send_aw(input logic [31:0] a, output bit ok);
    logic h;
    bus.AWADDR = a; bus.AWVALID = 1'b1; ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      h = bus.AWREADY;
      @(negedge ACLK);
      if (h) begin ok = 1'b1; break; end
    end
    bus.AWVALID = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, output bit ok);
    logic h;
    bus.ARADDR = a; bus.ARVALID = 1'b1; ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      h = bus.ARREADY;
      @(negedge ACLK);
      if (h) begin ok = 1'b1; break; end
    end
    bus.ARVALID = 1'b0;
  endtask

  task automatic wait_b(output logic [1:0] r, output int lat, output bit ok);
    bus.BREADY = 1'b1; ok = 1'b0; lat = 0; r = 2'bxx;
    for (int n = 0; n < 20; n++) begin
      if (bus.BVALID) begin
        r = bus.BRESP; ok = 1'b1;
        @(negedge ACLK);
        break;
      end
      @(negedge ACLK);
      lat++;
    end
    bus.BREADY = 1'b0;
  endtask

  task automatic wait_r(output logic [31:0] d, output logic [1:0] r, output int lat,
                        output bit ok);
    bus.RREADY = 1'b1; ok = 1'b0; lat = 0; d = 'x; r = 2'bxx;
    for (int n = 0; n < 20; n++) begin
      if (bus.RVALID) begin
        d = bus.RDATA; r = bus.RRESP; ok = 1'b1;
        @(negedge ACLK);
        break;
      end
      @(negedge ACLK);
      lat++;
    end
    bus.RREADY = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    output bit ok, output logic [1:0] r, output int lat);
    bit ok1, ok2;
    push_write(a, d, s);
    write_both(a, d, s, ok1);
    wait_b(r, lat, ok2);
    ok = ok1 && ok2;
  endtask

  task automatic rd(input logic [31:0] a, output bit ok, output logic [31:0] d,
                    output logic [1:0] r, output int lat);
    bit ok1, ok2;
    push_read(a);
    send_ar(a, ok1);
    wait_r(d, r, lat, ok2);
    ok = ok1 && ok2;
  endtask

  // ---- scenarios ----
  task automatic test_reset;
    bit ok; logic [31:0] d; logic [1:0] r; int lat; rexp_t e;
    ARESET = 1'b1;
    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    clear_model();
    repeat (2) @(negedge ACLK);
    total++;
    if ({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID, bus.BRESP,
         bus.RRESP, bus.RDATA} !== 41'h0) begin
      bad++;
      $display("FAIL reset_outputs: aw/w/ar_rdy=%b%b%b bvld=%b rvld=%b bresp=%h rresp=%h rdata=%h, required all 0",
               bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID, bus.BRESP,
               bus.RRESP, bus.RDATA);
    end
    ARESET = 1'b0;
    @(negedge ACLK);
    total++;
    if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b111) begin
      bad++;
      $display("FAIL ready_after_reset: aw/w/ar_rdy=%b%b%b, required 111",
               bus.AWREADY, bus.WREADY, bus.ARREADY);
    end
    rd(32'h0, ok, d, r, lat);
    e = rq.pop_front();
    total++;
    if (!ok || d !== e.data || r !== e.resp || lat != 0) begin
      bad++;
      $display("FAIL rd_0_after_reset: ok=%0b data=%h resp=%h lat=%0d, required %h/%h lat=0",
               ok, d, r, lat, e.data, e.resp);
    end
  endtask

  task automatic test_write_read;
    bit ok; logic [31:0] d; logic [1:0] r; int lat; rexp_t e; logic [1:0] eb;
    wr(32'h8, 32'hDEADBEEF, 4'hF, ok, r, lat);
    eb = bq.pop_front();
    total++;
    if (!ok || r !== eb || lat != 0) begin
      bad++;
      $display("FAIL wr_8: ok=%0b resp=%h lat=%0d, required resp=%h lat=0", ok, r, lat, eb);
    end
    rd(32'h8, ok, d, r, lat);
    e = rq.pop_front();
    total++;
    if (!ok || d !== e.data || r !== e.resp || lat != 0) begin
      bad++;
      $display("FAIL rd_8: ok=%0b data=%h resp=%h lat=%0d, required %h/%h lat=0",
               ok, d, r, lat, e.data, e.resp);
    end
  endtask

  task automatic test_split_strobe;
    bit ok, ok2; logic [31:0] d; logic [1:0] r; int lat; rexp_t e; logic [1:0] eb;
    wr(32'hC, 32'h11223344, 4'hF, ok, r, lat);
    eb = bq.pop_front();
    total++;
    if (!ok || r !== eb) begin
      bad++;
      $display("FAIL wr_c_full: ok=%0b resp=%h, required %h", ok, r, eb);
    end
    // W alone first, AW three cycles later
    push_write(32'hC, 32'h000000AA, 4'h1);
    bus.WDATA = 32'h000000AA; bus.WSTRB = 4'h1; bus.WVALID = 1'b1;
    @(negedge ACLK);
    bus.WVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (bus.BVALID !== 1'b0 || bus.WREADY !== 1'b0) begin
        bad++;
        $display("FAIL split_wait_aw[%0d]: bvld=%b wrdy=%b, required 0/0", i, bus.BVALID, bus.WREADY);
      end
      @(negedge ACLK);
    end
    send_aw(32'hC, ok);
    wait_b(r, lat, ok2);
    eb = bq.pop_front();
    total++;
    if (!ok || !ok2 || r !== eb || lat != 0) begin
      bad++;
      $display("FAIL split_b: ok=%0b%0b resp=%h lat=%0d, required resp=%h lat=0", ok, ok2, r, lat, eb);
    end
    rd(32'hC, ok, d, r, lat);
    e = rq.pop_front();
    total++;
    if (!ok || d !== e.data || r !== e.resp) begin
      bad++;
      $display("FAIL rd_strobe_merge: data=%h resp=%h, required %h/%h", d, r, e.data, e.resp);
    end
  endtask

  task automatic test_out_of_range;
    bit ok; logic [31:0] d; logic [1:0] r; int lat; rexp_t e; logic [1:0] eb;
    logic [31:0] addrs [4];
    addrs[0] = 32'h0; addrs[1] = 32'h40; addrs[2] = 32'h7C; addrs[3] = 32'h3C;
    wr(32'h0, 32'hCAFEF00D, 4'hF, ok, r, lat);
    eb = bq.pop_front();
    wr(32'h40, 32'hFFFFFFFF, 4'hF, ok, r, lat);
    eb = bq.pop_front();
    total++;
    if (!ok || r !== eb) begin
      bad++;
      $display("FAIL wr_oor_40: ok=%0b resp=%h, required %h", ok, r, eb);
    end
    wr(32'h7C, 32'h12345678, 4'hF, ok, r, lat);
    eb = bq.pop_front();
    total++;
    if (!ok || r !== eb) begin
      bad++;
      $display("FAIL wr_oor_7c: ok=%0b resp=%h, required %h", ok, r, eb);
    end
    for (int i = 0; i < 4; i++) begin
      rd(addrs[i], ok, d, r, lat);
      e = rq.pop_front();
      total++;
      if (!ok || d !== e.data || r !== e.resp) begin
        bad++;
        $display("FAIL rd_range[%h]: ok=%0b data=%h resp=%h, required %h/%h",
                 addrs[i], ok, d, r, e.data, e.resp);
      end
    end
  endtask

  task automatic test_backpressure;
    bit ok, ok2; logic [31:0] d; logic [1:0] r; int lat; rexp_t e; logic [1:0] eb;
    push_write(32'h4, 32'h0BADCAFE, 4'hF);
    eb = bq.pop_front();
    write_both(32'h4, 32'h0BADCAFE, 4'hF, ok);
    bus.AWVALID = 1'b1; bus.AWADDR = 32'h10;  // offered but must not be taken
    for (int i = 0; i < 5; i++) begin
      total++;
      if (!ok || bus.BVALID !== 1'b1 || bus.BRESP !== eb || bus.AWREADY !== 1'b0 ||
          bus.WREADY !== 1'b0) begin
        bad++;
        $display("FAIL b_hold[%0d]: bvld=%b bresp=%h awrdy=%b wrdy=%b, required 1/%h/0/0",
                 i, bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY, eb);
      end
      @(negedge ACLK);
    end
    bus.AWVALID = 1'b0;
    wait_b(r, lat, ok2);
    total++;
    if (!ok2 || r !== eb || lat != 0) begin
      bad++;
      $display("FAIL b_release: resp=%h lat=%0d, required %h lat=0", r, lat, eb);
    end
    push_read(32'h4);
    e = rq.pop_front();
    send_ar(32'h4, ok);
    bus.ARVALID = 1'b1; bus.ARADDR = 32'h0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (!ok || bus.RVALID !== 1'b1 || bus.RDATA !== e.data || bus.RRESP !== e.resp ||
          bus.ARREADY !== 1'b0) begin
        bad++;
        $display("FAIL r_hold[%0d]: rvld=%b rdata=%h rresp=%h arrdy=%b, required 1/%h/%h/0",
                 i, bus.RVALID, bus.RDATA, bus.RRESP, bus.ARREADY, e.data, e.resp);
      end
      @(negedge ACLK);
    end
    bus.ARVALID = 1'b0;
    wait_r(d, r, lat, ok2);
    total++;
    if (!ok2 || d !== e.data || r !== e.resp || lat != 0) begin
      bad++;
      $display("FAIL r_release: data=%h resp=%h lat=%0d, required %h/%h lat=0",
               d, r, lat, e.data, e.resp);
    end
  endtask

  task automatic test_collision;
    bit ok, ok2; logic [31:0] d; logic [1:0] r; int lat; rexp_t e; logic [1:0] eb;
    wr(32'h8, 32'h1, 4'hF, ok, r, lat);
    eb = bq.pop_front();
    push_read(32'h8);             // captures the pre-write value
    push_write(32'h8, 32'h5, 4'hF);
    total++;
    if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b111) begin
      bad++;
      $display("FAIL coll_ready: aw/w/ar_rdy=%b%b%b, required 111",
               bus.AWREADY, bus.WREADY, bus.ARREADY);
    end
    bus.AWADDR = 32'h8; bus.AWVALID = 1'b1;
    bus.WDATA = 32'h5; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    bus.ARADDR = 32'h8; bus.ARVALID = 1'b1;
    @(negedge ACLK);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    wait_b(r, lat, ok);
    eb = bq.pop_front();
    total++;
    if (!ok || r !== eb || lat != 0) begin
      bad++;
      $display("FAIL coll_b: ok=%0b resp=%h lat=%0d, required %h lat=0", ok, r, lat, eb);
    end
    wait_r(d, r, lat, ok);
    e = rq.pop_front();
    total++;
    if (!ok || d !== e.data || r !== e.resp) begin
      bad++;
      $display("FAIL coll_r_old: data=%h resp=%h, required %h/%h", d, r, e.data, e.resp);
    end
    rd(32'h8, ok2, d, r, lat);
    e = rq.pop_front();
    total++;
    if (!ok2 || d !== e.data || r !== e.resp) begin
      bad++;
      $display("FAIL coll_r_new: data=%h resp=%h, required %h/%h", d, r, e.data, e.resp);
    end
  endtask

  task automatic test_reset_abort;
    bit ok; logic [31:0] d; logic [1:0] r; int lat; rexp_t e;
    logic [31:0] addrs [2];
    addrs[0] = 32'h8; addrs[1] = 32'h10;
    send_aw(32'h10, ok);          // write now waits for W
    total++;
    if (!ok || bus.BVALID !== 1'b0) begin
      bad++;
      $display("FAIL abort_aw: ok=%0b bvld=%b, required 1/0", ok, bus.BVALID);
    end
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    clear_model();
    bus.WDATA = 32'h77; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (bus.WVALID && bus.WREADY) begin
        @(negedge ACLK);
        bus.WVALID = 1'b0;
      end else begin
        @(negedge ACLK);
      end
      total++;
      if (bus.BVALID !== 1'b0) begin
        bad++;
        $display("FAIL abort_no_b[%0d]: bvld=%b, required 0", i, bus.BVALID);
      end
    end
    bus.WVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd(addrs[i], ok, d, r, lat);
      e = rq.pop_front();
      total++;
      if (!ok || d !== e.data || r !== e.resp) begin
        bad++;
        $display("FAIL abort_cleared[%h]: ok=%0b data=%h resp=%h, required %h/%h",
                 addrs[i], ok, d, r, e.data, e.resp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_split_strobe();
    test_out_of_range();
    test_backpressure();
    test_collision();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave.md
# axi4_lite_slave

Synthesizable AXI4-Lite slave that backs a small word-addressed register memory and answers the BFM-driven master in the OOTB environment. It sits directly downstream of the master/BFM: it consumes AW/W/AR requests and produces B and R responses. It is the DUT slave that the testbench top instantiates and the checker compares against.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; fixed at 32 (WSTRB is 4 bits).
- DEPTH, 16, number of 32-bit words; power of two, 2..256.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- AWADDR  in  ADDR_WIDTH  write address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  32  write data.
- WSTRB  in  4  byte enables; bit i enables WDATA[8i+7:8i].
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response: OKAY=2'b00 or SLVERR=2'b10.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  ADDR_WIDTH  read address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  32  read data.
- RRESP  out  2  read response.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.

## Operation
- Word index = addr[log2(DEPTH)+1:2]. addr[1:0] is ignored. An address is in range iff addr < 4*DEPTH; an out-of-range address gets SLVERR, does no write, and returns RDATA=0.
- Write FSM states:
  - WR_IDLE: AWREADY=1, WREADY=1. AW and W may complete in the same cycle or in either order. Only AW completes -> WR_WAIT_W. Only W completes -> WR_WAIT_AW. Both complete -> commit and go to WR_RESP.
  - WR_WAIT_W: AWREADY=0, WREADY=1. W completes -> commit and go to WR_RESP.
  - WR_WAIT_AW: AWREADY=1, WREADY=0. AW completes -> commit and go to WR_RESP.
  - WR_RESP: BVALID=1 and BRESP held stable. BREADY -> WR_IDLE.
- Commit: the memory write is applied on the same edge as the last of the AW/W handshakes. Each byte lane is written only where its WSTRB bit is 1. WSTRB=0 in range still returns OKAY.
- Read FSM states:
  - RD_IDLE: ARREADY=1. AR handshake -> capture mem[idx] into RDATA and set RRESP, then go to RD_DATA.
  - RD_DATA: ARREADY=0, RVALID=1, RDATA/RRESP held. RREADY -> RD_IDLE.
- The read and write FSMs are independent; both may be in flight at once.

## Timing
- Reset (ARESET high at an edge): all memory words 0; both FSMs go to idle. Outputs: AWREADY=0, WREADY=0, ARREADY=0, BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0.
- Ready signals are registered. They rise in the first cycle after ARESET is deasserted.
- Reset asserted mid-transaction aborts it. A half-captured write is discarded, and any pending B/R response is dropped.
- Write latency: last AW/W handshake at edge N gives BVALID=1 in cycle N+1. Minimum write-to-write turnaround is 2 cycles with BREADY held high.
- Read latency: AR handshake at edge N gives RVALID in cycle N+1. With RREADY held high, a new AR is accepted every 2 cycles.
- Read and write to the same word on the same edge: the read returns the old value.
- Backpressure: BVALID and RVALID stay high, with payload stable, until their ready is seen. No new request is accepted on that channel meanwhile.

## Structure
- Shared package axi4_lite_Defs holds:
  - resp_t enum: OKAY=2'b00, SLVERR=2'b10.
  - ADDR_WIDTH and DATA_WIDTH constants.
  - wr_state_t and rd_state_t enums.
- Sub-module axi4_lite_regmem holds the DEPTH×32 storage. It has one byte-enabled write port, one registered read port, and synchronous clear on ARESET.
- axi4_lite_slave holds the two FSMs, address decode, and response generation.

## Test plan
- Reset: hold ARESET for 2 cycles, then release. All outputs are 0 during reset. AWREADY, WREADY and ARREADY are 1 one cycle after release. A read of 0x0 returns 0/OKAY.
- Write/read: AW=0x8 and W=0xDEADBEEF with WSTRB=4'hF in the same cycle give BVALID the next cycle with OKAY. A read of 0x8 returns 0xDEADBEEF/OKAY one cycle after the AR handshake.
- Split handshake and strobes:
  - W (0x000000AA, WSTRB=4'h1) is sent 3 cycles before AW=0xC. BVALID is 1 only after the AW handshake.
  - A previous value of 0x11223344 then reads back as 0x112233AA.
- Out of range (DEPTH=16): a write to 0x40 gives SLVERR and leaves memory unchanged. A read of 0x40 gives RDATA=0 with SLVERR.
- Backpressure: BREADY and RREADY are held low for 5 cycles. BVALID/BRESP and RVALID/RDATA stay stable for those 5 cycles. AWREADY and ARREADY stay 0 until the handshake completes.
- Collision:
  - A write of 0x5 to word 2 (address 0x8, previous value 0x1) commits on the same edge as the AR handshake for 0x8. The read returns 0x1.
  - A following read returns 0x5.
  - ARESET asserted while a write is in WR_WAIT_W clears the write, and no BVALID follows.
